wts_noise_envelope: RTL and testbench
=====================================

# wts_noise_envelope

Downstream consumer of the wave table sound noise generator. It takes the 1-bit pseudo-random `noise` stream and converts it into a signed 8-bit noise-channel sample. The sample's amplitude follows a 4-bit ADSR envelope (attack, decay, sustain, release) and is scaled by a 4-bit channel volume. All timing runs off the shared 3.579 MHz `active` pulse, and the output feeds the channel mixer.

## Interface
Parameters:
- `PRESCALE_BITS`, 8: width of the `active` prescaler; one envelope tick every 2^PRESCALE_BITS `active` pulses.

Ports:
- `clk`  in  1  system clock, single clock domain.
- `nreset`  in  1  reset, asynchronous, active-low; the only reset.
- `active`  in  1  3.579 MHz timing pulse, one `clk` wide.
- `noise`  in  1  noise bit from the noise generator.
- `key_on`  in  1  level-sensitive gate; a rising edge starts a note, low releases it.
- `reg_attack_rate`  in  4  attack step period minus one, in envelope ticks.
- `reg_decay_rate`  in  4  decay step period minus one.
- `reg_sustain_level`  in  4  sustain level, 0..15.
- `reg_release_rate`  in  4  release step period minus one.
- `reg_volume`  in  4  channel volume, 0..15.
- `sample`  out  8  signed two's-complement noise sample.
- `level`  out  4  current envelope level.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- Prescaler: counts `active` pulses. `env_tick` is high for one `clk` on the `active` pulse where the prescaler wraps from all-ones to 0.
- Rate timer: 4-bit counter, advanced only on `env_tick`.
  - On a tick, if `rate_cnt >= current stage rate`, then `step` = 1 and `rate_cnt` ← 0.
  - Otherwise `rate_cnt` increments.
  - The step period is therefore (rate+1) ticks. Rate 0 steps every tick.
  - The `>=` compare makes a mid-stage rate decrease take effect without wrapping.
- States:
  - IDLE: level is 0 and holds. A `key_on` rising edge goes to ATTACK.
  - ATTACK: on each step, level += 1. On the step that makes level 15, go to DECAY.
  - DECAY:
    - If level <= sustain, go to SUSTAIN immediately with no step; this covers sustain = 15.
    - Otherwise level -= 1 per step. When level reaches sustain, go to SUSTAIN.
  - SUSTAIN: level holds.
  - RELEASE: on each step, level -= 1. When level reaches 0, go to IDLE. Entering RELEASE at level 0 goes to IDLE on the next `clk`.
- `key_on` low in ATTACK, DECAY or SUSTAIN: go to RELEASE on the next `clk` and clear `rate_cnt`.
- `key_on` rising edge: detected every `clk` against a registered copy of `key_on`.
  - From any state, go to ATTACK, clear `rate_cnt`, and keep the current level (retrigger with no click).
- Priority within one `clk`: rising edge > release request > step.
- Level never wraps; it saturates at 0 and 15.
- Amplitude: `amp` = (level × reg_volume) >> 1. The product is 8-bit unsigned, so `amp` is 0..112 and fits in 7 bits.
- Sample:
  - On each `active` pulse, `sample` ← +amp if `noise` = 1, else −amp, sign-extended to 8 bits.
  - Between `active` pulses, `sample` holds.
  - `noise` and `level` are sampled on the same `active` pulse.

## Timing
- Reset values: `sample` = 0, `level` = 0, `busy` = 0, state IDLE, prescaler 0, `rate_cnt` 0, `key_on` history 0.
- `sample` is valid one `clk` after the `active` pulse that produced it.
- `level` changes one `clk` after the step (the `env_tick` edge). The `sample` computed on that same `active` pulse uses the old level.
- `key_on` to ATTACK: 2 `clk` (edge register, then state update). `busy` rises in the same cycle as the state change.
- Register inputs are used live; there is no shadowing. Changes take effect at the next compare or sample.
- Asserting reset mid-note forces all reset values immediately. After release, the block is in IDLE with no pending edge.

## Structure
- Shared package/defines file `wts_noise_envelope_defs`: state encodings (IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4; 3 bits), `LEVEL_MAX` = 15, and the default for `PRESCALE_BITS`.
- One sub-module, `wts_env_rate_timer`: prescaler, `env_tick`, `rate_cnt`, and the `step` output. Inputs are `rate` and `clear`.
- The state machine, level register and sample path live in the top module.

## Test plan
- Reset: hold `nreset` low with random inputs → `sample` = 0, `level` = 0, `busy` = 0; after release, still IDLE.
- Attack/decay: all rates 0, sustain 8, volume 15, `key_on` held high →
  - `level` reaches 15 after 15 ticks (15×256 `active` pulses);
  - `level` reaches 8 after 7 more ticks;
  - `level` then stays at 8.
- Sample sign and scale: level 15, volume 15 →
  - `noise` = 1 gives `sample` = 0x70 (+112);
  - `noise` = 0 gives `sample` = 0x90 (−112);
  - volume 0 gives `sample` = 0x00.
- Release: from SUSTAIN at 8 with release rate 3, drop `key_on` → `level` decrements every 4 ticks, IDLE after 32 ticks, then `busy` = 0.
- Retrigger: raise `key_on` during RELEASE at level 5 → state goes to ATTACK, level continues 5→6 on the next step, and `rate_cnt` is cleared.
- Simultaneous events and boundaries:
  - A `key_on` rising edge in the same `clk` as a release step → ATTACK wins and no decrement occurs.
  - Sustain 15 → DECAY passes straight to SUSTAIN at 15.

Source files
------------

// File: rtl/wts_noise_envelope_defs.sv
// rtl/wts_noise_envelope_defs.sv - shared state encodings and constants for the noise envelope
package wts_noise_envelope_defs;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } env_state_t;

  localparam logic [3:0] LEVEL_MAX = 4'd15;
  localparam int PRESCALE_BITS_DEFAULT = 8;

  // (level * volume) >> 1; the product tops out at 225, so 7 bits of result suffice.
  function automatic logic [6:0] calc_amp(input logic [3:0] lvl, input logic [3:0] vol);
    logic [7:0] prod;
    prod = {4'b0000, lvl} * {4'b0000, vol};
    return prod[7:1];
  endfunction

endpackage

// File: rtl/wts_env_rate_timer.sv
// rtl/wts_env_rate_timer.sv - active prescaler and per-stage rate counter producing envelope steps
module wts_env_rate_timer
  import wts_noise_envelope_defs::*;
#(
  parameter int PRESCALE_BITS = PRESCALE_BITS_DEFAULT
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       active,
  input  logic       clear,
  input  logic [3:0] rate,
  output logic       step
);

  logic [PRESCALE_BITS-1:0] prescale;
  logic [3:0]               rate_cnt;
  logic                     env_tick;

  assign env_tick = active && (prescale == '1);
  // >= rather than == so a rate lowered mid-stage steps at once instead of wrapping.
  assign step     = env_tick && (rate_cnt >= rate);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      prescale <= '0;
      rate_cnt <= 4'd0;
    end else begin
      if (active) begin
        prescale <= prescale + 1'b1;
      end
      if (clear) begin
        rate_cnt <= 4'd0;
      end else if (env_tick) begin
        rate_cnt <= step ? 4'd0 : rate_cnt + 4'd1;
      end
    end
  end

endmodule

// File: rtl/wts_noise_envelope.sv
// rtl/wts_noise_envelope.sv - ADSR-shaped, volume-scaled signed sample from the 1-bit noise stream
module wts_noise_envelope
  import wts_noise_envelope_defs::*;
#(
  parameter int PRESCALE_BITS = PRESCALE_BITS_DEFAULT
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       active,
  input  logic       noise,
  input  logic       key_on,
  input  logic [3:0] reg_attack_rate,
  input  logic [3:0] reg_decay_rate,
  input  logic [3:0] reg_sustain_level,
  input  logic [3:0] reg_release_rate,
  input  logic [3:0] reg_volume,
  output logic [7:0] sample,
  output logic [3:0] level,
  output logic       busy
);

  env_state_t state;
  logic       key_sync;
  logic       key_prev;
  logic       key_rise;
  logic       rel_req;
  logic       clear;
  logic       step;
  logic [3:0] cur_rate;
  logic [6:0] amp;

  assign key_rise = key_sync & ~key_prev;
  assign rel_req  = ~key_on & ((state == ST_ATTACK) || (state == ST_DECAY) || (state == ST_SUSTAIN));
  assign clear    = key_rise | rel_req;
  assign amp      = calc_amp(level, reg_volume);
  assign busy     = (state != ST_IDLE);

  always_comb begin
    cur_rate = 4'd0;
    case (state)
      ST_ATTACK:  cur_rate = reg_attack_rate;
      ST_DECAY:   cur_rate = reg_decay_rate;
      ST_RELEASE: cur_rate = reg_release_rate;
      default:    cur_rate = 4'd0;
    endcase
  end

  wts_env_rate_timer #(
    .PRESCALE_BITS(PRESCALE_BITS)
  ) u_rate_timer (
    .clk    (clk),
    .nreset (nreset),
    .active (active),
    .clear  (clear),
    .rate   (cur_rate),
    .step   (step)
  );

  // Retrigger keeps the current level so a re-keyed note ramps up without a click.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state    <= ST_IDLE;
      level    <= 4'd0;
      key_sync <= 1'b0;
      key_prev <= 1'b0;
    end else begin
      key_sync <= key_on;
      key_prev <= key_sync;
      if (key_rise) begin
        state <= ST_ATTACK;
      end else if (rel_req) begin
        state <= ST_RELEASE;
      end else begin
        case (state)
          ST_ATTACK: begin
            if (step) begin
              if (level >= LEVEL_MAX - 4'd1) begin
                level <= LEVEL_MAX;
                state <= ST_DECAY;
              end else begin
                level <= level + 4'd1;
              end
            end
          end
          ST_DECAY: begin
            if (level <= reg_sustain_level) begin
              state <= ST_SUSTAIN;
            end else if (step) begin
              level <= level - 4'd1;
              if ((level - 4'd1) == reg_sustain_level) begin
                state <= ST_SUSTAIN;
              end
            end
          end
          ST_RELEASE: begin
            if (level == 4'd0) begin
              state <= ST_IDLE;
            end else if (step) begin
              level <= level - 4'd1;
              if (level == 4'd1) begin
                state <= ST_IDLE;
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      sample <= 8'd0;
    end else if (active) begin
      sample <= noise ? {1'b0, amp} : 8'd0 - {1'b0, amp};
    end
  end

endmodule

// File: tb/tb_wts_noise_envelope.sv
// tb/tb_wts_noise_envelope.sv - directed scoreboard bench for the noise envelope
module tb_wts_noise_envelope;

  localparam int PB  = 8;
  localparam int PRE = 1 << PB;

  logic       clk = 1'b0;
  logic       nreset = 1'b0;
  logic       active = 1'b0;
  logic       noise = 1'b0;
  logic       key_on = 1'b0;
  logic [3:0] reg_attack_rate = 4'd0;
  logic [3:0] reg_decay_rate = 4'd0;
  logic [3:0] reg_sustain_level = 4'd0;
  logic [3:0] reg_release_rate = 4'd0;
  logic [3:0] reg_volume = 4'd0;
  logic [7:0] sample;
  logic [3:0] level;
  logic       busy;

  int npass = 0;
  int nfail = 0;
  int ntotal = 0;
  int pulses = 0;

  logic [3:0] lvl_q[$];
  logic [7:0] smp_q[$];

  wts_noise_envelope #(.PRESCALE_BITS(PB)) dut (
    .clk               (clk),
    .nreset            (nreset),
    .active            (active),
    .noise             (noise),
    .key_on            (key_on),
    .reg_attack_rate   (reg_attack_rate),
    .reg_decay_rate    (reg_decay_rate),
    .reg_sustain_level (reg_sustain_level),
    .reg_release_rate  (reg_release_rate),
    .reg_volume        (reg_volume),
    .sample            (sample),
    .level             (level),
    .busy              (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse();
    active = 1'b1;
    noise  = 1'($urandom);
    @(posedge clk);
    #1;
    active = 1'b0;
    pulses++;
    @(posedge clk);
    #1;
  endtask

  task automatic to_pre_tick();
    while (pulses % PRE != PRE - 1) pulse();
  endtask

  task automatic run_ticks(input int n, input string tag);
    for (int t = 0; t < n; t++) begin
      to_pre_tick();
      pulse();
      if (lvl_q.size() > 0) check(tag, {4'b0, level}, {4'b0, lvl_q.pop_front()});
      else check({tag, "_q_empty"}, 8'd1, 8'd0);
    end
  endtask

  task automatic spulse(input logic nz, input string tag);
    active = 1'b1;
    noise  = nz;
    @(posedge clk);
    #1;
    active = 1'b0;
    pulses++;
    if (smp_q.size() > 0) check(tag, sample, smp_q.pop_front());
    else check({tag, "_q_empty"}, 8'd1, 8'd0);
  endtask

  task automatic random_reset();
    #1;
    nreset = 1'b0;
    #1;
    check("rst_sample_now", sample, 8'h00);
    check("rst_level_now", {4'b0, level}, 8'h00);
    check("rst_busy_now", {7'b0, busy}, 8'h00);
    for (int i = 0; i < 6; i++) begin
      active            = 1'($urandom);
      noise             = 1'($urandom);
      key_on            = 1'($urandom);
      reg_attack_rate   = 4'($urandom);
      reg_volume        = 4'($urandom);
      reg_sustain_level = 4'($urandom);
      @(posedge clk);
      #1;
    end
    check("rst_sample_hold", sample, 8'h00);
    check("rst_level_hold", {4'b0, level}, 8'h00);
    check("rst_busy_hold", {7'b0, busy}, 8'h00);
    active = 1'b0;
    key_on = 1'b0;
    nreset = 1'b1;
    pulses = 0;
    idle(4);
    check("post_rst_busy", {7'b0, busy}, 8'h00);
    check("post_rst_level", {4'b0, level}, 8'h00);
  endtask

  initial begin
    // Reset with random inputs
    random_reset();

    // Attack to 15, decay to sustain 8, then hold
    reg_attack_rate   = 4'd0;
    reg_decay_rate    = 4'd0;
    reg_release_rate  = 4'd0;
    reg_sustain_level = 4'd8;
    reg_volume        = 4'd15;
    key_on = 1'b1;
    idle(1);
    check("key_lat_1clk_busy", {7'b0, busy}, 8'h00);
    idle(1);
    check("key_lat_2clk_busy", {7'b0, busy}, 8'h01);
    for (int i = 1; i <= 15; i++) lvl_q.push_back(4'(i));
    run_ticks(15, "attack");
    for (int i = 14; i >= 8; i--) lvl_q.push_back(4'(i));
    run_ticks(7, "decay");
    lvl_q.push_back(4'd8);
    lvl_q.push_back(4'd8);
    run_ticks(2, "sustain8");
    check("sustain_busy", {7'b0, busy}, 8'h01);

    // Release from 8 at rate 3
    reg_release_rate = 4'd3;
    key_on = 1'b0;
    idle(2);
    for (int t = 1; t <= 32; t++) lvl_q.push_back(4'(8 - t / 4));
    run_ticks(32, "release");
    check("release_idle_busy", {7'b0, busy}, 8'h00);
    idle(3);
    check("idle_level_hold", {4'b0, level}, 8'h00);

    // Retrigger during release at level 5 with a nonzero rate count
    reg_attack_rate = 4'd0;
    key_on = 1'b1;
    idle(2);
    for (int i = 1; i <= 5; i++) lvl_q.push_back(4'(i));
    run_ticks(5, "attack_to5");
    reg_release_rate = 4'd3;
    key_on = 1'b0;
    idle(2);
    lvl_q.push_back(4'd5);
    lvl_q.push_back(4'd5);
    run_ticks(2, "release_at5");
    reg_attack_rate = 4'd3;
    key_on = 1'b1;
    idle(2);
    check("retrig_busy", {7'b0, busy}, 8'h01);
    lvl_q.push_back(4'd5);
    lvl_q.push_back(4'd5);
    lvl_q.push_back(4'd5);
    lvl_q.push_back(4'd6);
    run_ticks(4, "retrig_ramp");

    // Rising edge in the same clk as a release step: attack wins, no decrement
    reg_attack_rate  = 4'd0;
    reg_release_rate = 4'd0;
    key_on = 1'b0;
    idle(2);
    to_pre_tick();
    key_on = 1'b1;
    idle(1);
    pulse();
    check("edge_vs_step_level", {4'b0, level}, 8'h06);
    check("edge_vs_step_busy", {7'b0, busy}, 8'h01);
    lvl_q.push_back(4'd7);
    run_ticks(1, "edge_vs_step_next");

    // Mid-note reset
    random_reset();

    // Sustain 15 passes straight through decay
    reg_attack_rate   = 4'd0;
    reg_decay_rate    = 4'd0;
    reg_sustain_level = 4'd15;
    reg_volume        = 4'd15;
    key_on = 1'b1;
    idle(2);
    for (int i = 1; i <= 15; i++) lvl_q.push_back(4'(i));
    run_ticks(15, "attack_s15");
    lvl_q.push_back(4'd15);
    lvl_q.push_back(4'd15);
    run_ticks(2, "sustain15");

    // Sample sign and scale at level 15
    smp_q.push_back(8'h70);
    spulse(1'b1, "sample_pos_112");
    noise = 1'b0;
    smp_q.push_back(8'h70);
    idle(2);
    check("sample_hold", sample, smp_q.pop_front());
    smp_q.push_back(8'h90);
    spulse(1'b0, "sample_neg_112");
    reg_volume = 4'd7;
    smp_q.push_back(8'hCC);
    spulse(1'b0, "sample_neg_52");
    smp_q.push_back(8'h34);
    spulse(1'b1, "sample_pos_52");
    reg_volume = 4'd0;
    smp_q.push_back(8'h00);
    spulse(1'b1, "sample_vol0");

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
